// File: rtl/cube_root_pkg.sv
// ============================================================================
// Package : cube_root_pkg
// Purpose : Shared widths, default timing and state encoding for the
//           cube-root sequencer and its residual stage.
// Contents: OP_W / ROOT_W / SQ_W / CUBE_W / DIFF_W width constants,
//           default calculator latency and clear length, state_e enum.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package cube_root_pkg;

   // Operand, root and intermediate product widths.
   localparam int OP_W   = 32;
   localparam int ROOT_W = 11;
   localparam int SQ_W   = 2 * ROOT_W;   // 22
   localparam int CUBE_W = 3 * ROOT_W;   // 33
   // One extra bit above the cube so the subtraction borrow is visible.
   localparam int DIFF_W = CUBE_W + 1;   // 34

   // Calculator timing defaults: 11 iterations + 1 settle, single-cycle clear.
   localparam int CALC_LATENCY_DEF = 12;
   localparam int CLEAR_CYCLES_DEF = 1;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_CLR  = 3'd1,
      ST_RUN  = 3'd2,
      ST_SQ   = 3'd3,
      ST_CUBE = 3'd4,
      ST_DONE = 3'd5
   } state_e;

endpackage : cube_root_pkg

`default_nettype wire

// File: rtl/cube_root_sequencer_residual.sv
// ============================================================================
// Module  : cube_residual
// Purpose : Two-stage registered multiply-subtract. Stage 1 squares the root,
//           stage 2 multiplies by the root again and subtracts the cube from
//           the operand, flagging a root whose cube overshoots the operand.
// Ports   : clock_i    - clock
//           clear_ni   - asynchronous active-low reset
//           sq_en_i    - load root^2 into the square register
//           cube_en_i  - load remainder / flags from square*root
//           operand_i  - 32-bit unsigned operand
//           root_i     - 11-bit root under test
//           rem_o      - operand - root^3, forced to 0 on error
//           err_o      - root^3 > operand
//           exact_o    - remainder is zero and no error
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cube_residual
   import cube_root_pkg::*;
(
   input  logic              clock_i,
   input  logic              clear_ni,
   input  logic              sq_en_i,
   input  logic              cube_en_i,
   input  logic [OP_W-1:0]   operand_i,
   input  logic [ROOT_W-1:0] root_i,
   output logic [OP_W-1:0]   rem_o,
   output logic              err_o,
   output logic              exact_o
);

   logic [SQ_W-1:0]   sq_q;
   logic [OP_W-1:0]   rem_q;
   logic              err_q;
   logic              exact_q;

   logic [SQ_W-1:0]   sq_d;
   logic [CUBE_W-1:0] cube_d;
   logic [DIFF_W-1:0] diff_d;
   logic              neg_d;

   always_comb begin
      sq_d   = SQ_W'(root_i) * SQ_W'(root_i);
      cube_d = CUBE_W'(sq_q) * CUBE_W'(root_i);
      // Both sides widened to 34 bits so a 2047^3 cube cannot wrap before
      // the sign bit is inspected.
      diff_d = {2'b00, operand_i} - {1'b0, cube_d};
      neg_d  = diff_d[DIFF_W-1];
   end

   always_ff @(posedge clock_i or negedge clear_ni) begin
      if (!clear_ni) begin
         sq_q    <= '0;
         rem_q   <= '0;
         err_q   <= 1'b0;
         exact_q <= 1'b0;
      end else begin
         if (sq_en_i) begin
            sq_q <= sq_d;
         end
         if (cube_en_i) begin
            if (neg_d) begin
               rem_q   <= '0;
               err_q   <= 1'b1;
               exact_q <= 1'b0;
            end else begin
               rem_q   <= diff_d[OP_W-1:0];
               err_q   <= 1'b0;
               exact_q <= (diff_d[OP_W-1:0] == '0);
            end
         end
      end
   end

   assign rem_o   = rem_q;
   assign err_o   = err_q;
   assign exact_o = exact_q;

endmodule : cube_residual

`default_nettype wire

// File: rtl/cube_root_sequencer.sv
// ============================================================================
// Module  : cube_root_sequencer
// Purpose : Control-and-check stage around the iterative cube-root
//           calculator. Accepts an operand, holds it on the calculator input,
//           pulses the calculator clear, waits the fixed iteration latency,
//           captures the root and reports root, residual and flags over a
//           valid/ready handshake with backpressure.
// Ports   : clock_i       - clock, rising edge active
//           clear_ni      - asynchronous active-low reset
//           in_valid_i    - operand offered
//           in_ready_o    - operand accepted this cycle if valid (IDLE only)
//           in_data_i     - 32-bit unsigned operand
//           calc_in_o     - operand held on the calculator input
//           calc_clear_o  - active-high calculator clear
//           calc_out_i    - 11-bit root from the calculator
//           res_valid_o   - result available
//           res_ready_i   - consumer accepts the result
//           res_root_o    - captured root
//           res_rem_o     - operand - root^3 (0 on error)
//           res_exact_o   - residual zero and no error
//           res_err_o     - root^3 exceeded the operand
//           busy_o        - any state other than IDLE
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module cube_root_sequencer
   import cube_root_pkg::*;
#(
   parameter int CALC_LATENCY = CALC_LATENCY_DEF,
   parameter int CLEAR_CYCLES = CLEAR_CYCLES_DEF
)(
   input  logic              clock_i,
   input  logic              clear_ni,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [OP_W-1:0]   in_data_i,
   output logic [OP_W-1:0]   calc_in_o,
   output logic              calc_clear_o,
   input  logic [ROOT_W-1:0] calc_out_i,
   output logic              res_valid_o,
   input  logic              res_ready_i,
   output logic [ROOT_W-1:0] res_root_o,
   output logic [OP_W-1:0]   res_rem_o,
   output logic              res_exact_o,
   output logic              res_err_o,
   output logic              busy_o
);

   // One counter is shared between the CLR and RUN phases; size it for the
   // longer of the two.
   localparam int CNT_MAX = (CALC_LATENCY > CLEAR_CYCLES) ? CALC_LATENCY : CLEAR_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_CYCLES - 1);
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(CALC_LATENCY - 1);

   state_e              state_q,   state_d;
   logic [CNT_W-1:0]    cnt_q,     cnt_d;
   logic [OP_W-1:0]     operand_q, operand_d;
   logic [ROOT_W-1:0]   root_q,    root_d;

   logic                in_ready_d;
   logic                calc_clear_d;
   logic                res_valid_d;
   logic                sq_en_d;
   logic                cube_en_d;

   // -------------------------------------------------------------------------
   // State and data registers
   // -------------------------------------------------------------------------
   always_ff @(posedge clock_i or negedge clear_ni) begin
      if (!clear_ni) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         operand_q <= '0;
         root_q    <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         operand_q <= operand_d;
         root_q    <= root_d;
      end
   end

   // -------------------------------------------------------------------------
   // Next-state and output decode
   // -------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      operand_d    = operand_q;
      root_d       = root_q;
      in_ready_d   = 1'b0;
      calc_clear_d = 1'b0;
      res_valid_d  = 1'b0;
      sq_en_d      = 1'b0;
      cube_en_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            in_ready_d   = 1'b1;
            calc_clear_d = 1'b1;
            cnt_d        = '0;
            if (in_valid_i) begin
               operand_d = in_data_i;
               state_d   = ST_CLR;
            end
         end

         ST_CLR: begin
            calc_clear_d = 1'b1;
            if (cnt_q == CLR_LAST) begin
               cnt_d   = '0;
               state_d = ST_RUN;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_RUN: begin
            // calc_out is only trusted on the terminal count edge.
            if (cnt_q == LAT_LAST) begin
               root_d  = calc_out_i;
               cnt_d   = '0;
               state_d = ST_SQ;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end

         ST_SQ: begin
            sq_en_d = 1'b1;
            state_d = ST_CUBE;
         end

         ST_CUBE: begin
            cube_en_d = 1'b1;
            state_d   = ST_DONE;
         end

         ST_DONE: begin
            // Returning to IDLE only here keeps a new accept at least one
            // cycle after the transfer edge.
            res_valid_d = 1'b1;
            if (res_ready_i) begin
               state_d = ST_IDLE;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Residual stage
   // -------------------------------------------------------------------------
   cube_residual u_residual (
      .clock_i   (clock_i),
      .clear_ni  (clear_ni),
      .sq_en_i   (sq_en_d),
      .cube_en_i (cube_en_d),
      .operand_i (operand_q),
      .root_i    (root_q),
      .rem_o     (res_rem_o),
      .err_o     (res_err_o),
      .exact_o   (res_exact_o)
   );

   assign in_ready_o   = in_ready_d;
   assign calc_clear_o = calc_clear_d;
   assign calc_in_o    = operand_q;
   assign res_valid_o  = res_valid_d;
   assign res_root_o   = root_q;
   assign busy_o       = (state_q != ST_IDLE);

endmodule : cube_root_sequencer

`default_nettype wire

// File: tb/tb_cube_root_sequencer.sv
// ============================================================================
// Module  : tb_cube_root_sequencer
// Purpose : Self-checking bench for cube_root_sequencer with a behavioural
//           calculator stand-in (true floor cube root, valid only after the
//           iteration latency, optionally off by one to mimic a fault).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cube_root_sequencer;

   localparam int LAT     = 12;
   localparam int CLRC    = 1;
   localparam int EXP_LAT = CLRC + LAT + 2;

   logic        clock     = 1'b0;
   logic        clear_n   = 1'b0;
   logic        in_valid  = 1'b0;
   logic [31:0] in_data   = '0;
   logic        res_ready = 1'b1;

   logic        in_ready;
   logic [31:0] calc_in;
   logic        calc_clear;
   logic [10:0] calc_out;
   logic        res_valid;
   logic [10:0] res_root;
   logic [31:0] res_rem;
   logic        res_exact;
   logic        res_err;
   logic        busy;

   int checks   = 0;
   int failures = 0;
   bit fault    = 1'b0;

   always #5 clock = ~clock;

   cube_root_sequencer #(
      .CALC_LATENCY (LAT),
      .CLEAR_CYCLES (CLRC)
   ) dut (
      .clock_i      (clock),
      .clear_ni     (clear_n),
      .in_valid_i   (in_valid),
      .in_ready_o   (in_ready),
      .in_data_i    (in_data),
      .calc_in_o    (calc_in),
      .calc_clear_o (calc_clear),
      .calc_out_i   (calc_out),
      .res_valid_o  (res_valid),
      .res_ready_i  (res_ready),
      .res_root_o   (res_root),
      .res_rem_o    (res_rem),
      .res_exact_o  (res_exact),
      .res_err_o    (res_err),
      .busy_o       (busy)
   );

   // Floor cube root by bitwise search on 64-bit arithmetic.
   function automatic longint unsigned icbrt(input longint unsigned x);
      longint unsigned r = 0;
      longint unsigned t;
      for (int b = 10; b >= 0; b--) begin
         t = r | (64'd1 << b);
         if (t * t * t <= x) r = t;
      end
      return r;
   endfunction

   // Calculator stand-in: counts edges with clear low; the answer is only
   // presented after LAT-1 such edges, otherwise an obviously wrong 2047.
   logic [4:0]  calc_cnt;
   logic [10:0] true_root;
   always @(posedge clock or negedge clear_n) begin
      if (!clear_n)              calc_cnt <= '0;
      else if (calc_clear)       calc_cnt <= '0;
      else if (calc_cnt != 5'd31) calc_cnt <= calc_cnt + 5'd1;
   end
   always_comb begin
      true_root = 11'(icbrt(64'(calc_in)));
      calc_out  = (calc_cnt >= 5'(LAT - 1)) ? (fault ? true_root + 11'd1 : true_root) : 11'h7FF;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Runs one operand end to end. Entered and left just after a negedge.
   task automatic process(input logic [31:0] x, input bit flt, input int stall);
      longint unsigned r, e_root, e_rem;
      bit              e_err, e_exact;
      int              n;
      logic [10:0]     h_root;
      logic [31:0]     h_rem;
      r = icbrt(64'(x));
      if (flt) begin
         e_root = r + 1; e_rem = 0; e_err = 1'b1; e_exact = 1'b0;
      end else begin
         e_root = r; e_rem = 64'(x) - r * r * r; e_err = 1'b0; e_exact = (e_rem == 0);
      end
      fault     = flt;
      res_ready = (stall == 0);

      chk("in_ready_idle", in_ready, 1);
      in_valid = 1'b1;
      in_data  = x;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      in_data  = $urandom;
      chk("clear_high", calc_clear, 1);
      chk("busy_run", busy, 1);
      @(negedge clock);
      chk("clear_low", calc_clear, 0);
      n = 1;
      while (!res_valid && n < 40) begin
         @(negedge clock);
         n++;
      end
      chk("latency", n, EXP_LAT);
      chk("root", res_root, e_root);
      chk("rem", res_rem, e_rem);
      chk("err", res_err, e_err);
      chk("exact", res_exact, e_exact);
      chk("calc_in_held", calc_in, x);
      h_root = res_root;
      h_rem  = res_rem;
      for (int i = 0; i < stall; i++) begin
         in_valid = 1'b1;
         in_data  = x ^ 32'h5A5A_0F0F;
         @(negedge clock);
         chk("stall_valid", res_valid, 1);
         chk("stall_in_ready", in_ready, 0);
         chk("stall_root", res_root, h_root);
         chk("stall_rem", res_rem, h_rem);
      end
      res_ready = 1'b1;
      @(negedge clock);
      in_valid = 1'b0;
      chk("valid_drop", res_valid, 0);
      chk("idle_after", busy, 0);
   endtask

   initial begin
      clear_n = 1'b0;
      repeat (2) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_valid", res_valid, 0);
      chk("rst_clear", calc_clear, 1);
      chk("rst_root", res_root, 0);
      chk("rst_rem", res_rem, 0);
      chk("rst_exact", res_exact, 0);
      chk("rst_err", res_err, 0);
      chk("rst_calc_in", calc_in, 0);
      clear_n = 1'b1;
      @(negedge clock);
      chk("post_rst_ready", in_ready, 1);

      process(32'd27, 1'b0, 0);
      process(32'hFFFF_FFFF, 1'b0, 0);
      process(32'd0, 1'b0, 5);
      process(32'd27, 1'b1, 0);

      // Abort in the middle of RUN.
      fault    = 1'b0;
      in_valid = 1'b1;
      in_data  = 32'd500;
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      repeat (4) @(negedge clock);
      clear_n = 1'b0;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_valid", res_valid, 0);
      chk("abort_clear", calc_clear, 1);
      repeat (3) @(negedge clock);
      clear_n = 1'b1;
      @(negedge clock);
      process(32'd1000, 1'b0, 0);

      // Back-to-back with res_ready held high.
      process(32'd8, 1'b0, 0);
      process(32'd9, 1'b0, 0);
      process(32'd64, 1'b0, 0);

      for (int k = 0; k < 8; k++) begin
         process($urandom, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 2)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_cube_root_sequencer

`default_nettype wire
